multicycle_core: RTL and testbench

Parametrised multicycle execution core that succeeds the fixed 16-bit CPU datapath. It contains a NUM_REGS×WIDTH register file, instruction register, immediate register, ALU result register, PC and status flags, all sequenced by an internal four-state controller. One 16-bit instruction is accepted per valid/ready handshake and retired three cycles later. It sits between the instruction fetch/memory logic and the board-level top.

---
 rtl/multicycle_core_pkg.sv | 62 ++++++
 rtl/multicycle_core_if.sv | 9 +
 rtl/multicycle_core_alu_unit.sv | 67 ++++++
 rtl/multicycle_core.sv | 126 ++++++++++++
 tb/tb_multicycle_core.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_core_pkg.sv
// Shared opcodes, controller state type and flag/field positions for multicycle_core.
// op_implemented() follows MULTICYCLE_CORE_SHIFT_EN: without it LSH/LSHI decode as illegal.
package multicycle_core_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_MOVI = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_CMPI = 4'hA;
  localparam logic [3:0] OP_LSH  = 4'hB;
  localparam logic [3:0] OP_LSHI = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  // flags = {C,L,F,Z,N}
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_C = 4;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  function automatic logic op_uses_rs(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV, OP_CMP, OP_LSH};
  endfunction

  function automatic logic op_sext_imm(input logic [3:0] op);
    return op inside {OP_ADDI, OP_SUBI, OP_CMPI, OP_LSHI};
  endfunction

  function automatic logic op_writes_rd(input logic [3:0] op);
    return !(op inside {OP_CMP, OP_CMPI});
  endfunction

  function automatic logic op_implemented(input logic [3:0] op);
`ifdef MULTICYCLE_CORE_SHIFT_EN
    return op <= OP_LSHI;
`else
    return op <= OP_CMPI;
`endif
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction handshake between the fetch logic (master) and multicycle_core (slave).
interface multicycle_core_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/multicycle_core_alu_unit.sv
// Combinational ALU for multicycle_core: result plus next {C,L,F,Z,N} from op, a (rd), b (operand).
// The signed-amount shifter exists only when MULTICYCLE_CORE_SHIFT_EN is defined.
module alu_unit
  import multicycle_core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       flags_in,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags_next
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           is_add;
  logic           is_sub;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign is_add = op inside {OP_ADD, OP_ADDI};
  assign is_sub = op inside {OP_SUB, OP_SUBI, OP_CMP, OP_CMPI};

`ifdef MULTICYCLE_CORE_SHIFT_EN
  // b[4:0] is a two's-complement amount: positive shifts left, negative shifts right.
  logic [4:0]       amt;
  logic [5:0]       mag;
  logic [WIDTH-1:0] shifted;

  assign amt     = b[4:0];
  assign mag     = amt[4] ? (6'd32 - {1'b0, amt}) : {1'b0, amt};
  assign shifted = (int'(mag) >= WIDTH) ? '0 : (amt[4] ? (a >> mag) : (a << mag));
`endif

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    result     = a;
    flags_next = flags_in;
    case (op)
      OP_ADD, OP_ADDI:                  result = sum[WIDTH-1:0];
      OP_SUB, OP_SUBI, OP_CMP, OP_CMPI: result = diff[WIDTH-1:0];
      OP_AND:                           result = a & b;
      OP_OR:                            result = a | b;
      OP_XOR:                           result = a ^ b;
      OP_MOV, OP_MOVI:                  result = b;
`ifdef MULTICYCLE_CORE_SHIFT_EN
      OP_LSH, OP_LSHI:                  result = shifted;
`endif
      default:                          result = a;
    endcase

    flags_next[FLAG_Z] = (result == '0);
    flags_next[FLAG_N] = result[WIDTH-1];
    if (is_add) begin
      flags_next[FLAG_C] = sum[WIDTH];
      flags_next[FLAG_L] = 1'b0;
      flags_next[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else if (is_sub) begin
      // The extra top bit of the difference is the borrow, i.e. unsigned a < b.
      flags_next[FLAG_C] = diff[WIDTH];
      flags_next[FLAG_L] = diff[WIDTH];
      flags_next[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle execution core: IR, operand/immediate latches, register file, PC and flags sequenced
// IDLE->DECODE->EXEC->WB. Define MULTICYCLE_CORE_SHIFT_EN to implement LSH/LSHI.
module multicycle_core
  import multicycle_core_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter int               NUM_REGS = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  multicycle_core_if.slave bus,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_out,
  output logic [4:0]       flags,
  output logic             done,
  output logic             illegal,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  localparam int AW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

  state_e           state;
  logic [15:0]      ir;
  logic [WIDTH-1:0] regs [NUM_REGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] imm_q;
  logic [4:0]       flags_nx;
  logic             bad_q;

  logic [3:0]       op;
  logic [3:0]       rd;
  logic [3:0]       rs;
  logic [WIDTH-1:0] imm_sext;
  logic [WIDTH-1:0] imm_zext;
  logic             decode_bad;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;

  // Out-of-range addresses read as 0 rather than indexing past the array.
  function automatic logic [WIDTH-1:0] reg_read(input logic [3:0] addr);
    return (int'(addr) < NUM_REGS) ? regs[addr[AW-1:0]] : '0;
  endfunction

  assign op       = ir[OP_HI:OP_LO];
  assign rd       = ir[RD_HI:RD_LO];
  assign rs       = ir[RS_HI:RS_LO];
  assign imm_sext = WIDTH'($signed(ir[IMM_HI:IMM_LO]));
  assign imm_zext = WIDTH'(ir[IMM_HI:IMM_LO]);

  // The rs field is only a register address for register-register opcodes.
  assign decode_bad = !op_implemented(op) || (int'(rd) >= NUM_REGS)
                    || (op_uses_rs(op) && (int'(rs) >= NUM_REGS));

  assign bus.instr_ready = (state == ST_IDLE);
  assign dbg_data        = reg_read(dbg_addr);
  assign alu_b           = op_uses_rs(op) ? op_b : imm_q;

  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .op         (op),
    .a          (op_a),
    .b          (alu_b),
    .flags_in   (flags),
    .result     (alu_res),
    .flags_next (alu_flags)
  );

  // NOTE: state is updated with <= so every register samples pre-edge values, whatever the order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      imm_q    <= '0;
      bad_q    <= 1'b0;
      alu_out  <= '0;
      flags_nx <= '0;
      flags    <= '0;
      pc       <= RESET_PC;
      done     <= 1'b0;
      illegal  <= 1'b0;
      // NOTE: the register file is architecturally zero after reset, so it is reset like any flop.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_a  <= reg_read(rd);
          op_b  <= reg_read(rs);
          imm_q <= op_sext_imm(op) ? imm_sext : imm_zext;
          bad_q <= decode_bad;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!bad_q) begin
            alu_out  <= alu_res;
            flags_nx <= alu_flags;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (!bad_q) begin
            flags <= flags_nx;
            if (op_writes_rd(op)) regs[rd[AW-1:0]] <= alu_out;
          end
          pc      <= pc + WIDTH'(1);
          done    <= 1'b1;
          illegal <= bad_q;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: directed scenarios plus random instructions checked
// against an arithmetic reference model; a second NUM_REGS=8 instance covers illegal fields and pc wrap.
`timescale 1ns/1ps
module tb_multicycle_core;

`ifdef MULTICYCLE_CORE_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_core_if bus();
  multicycle_core_if bus8();

  logic [15:0] pc, alu_out, dbg_data, pc8, alu_out8, dbg_data8;
  logic [4:0]  flags, flags8;
  logic        done, illegal, done8, illegal8;
  logic [3:0]  dbg_addr = 4'd0;
  logic [3:0]  dbg_addr8 = 4'd0;

  multicycle_core #(.WIDTH(16), .NUM_REGS(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .pc(pc), .alu_out(alu_out), .flags(flags),
    .done(done), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  multicycle_core #(.WIDTH(16), .NUM_REGS(8), .RESET_PC(16'hFFFE)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8), .pc(pc8), .alu_out(alu_out8), .flags(flags8),
    .done(done8), .illegal(illegal8), .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
  );

  logic sel8 = 1'b0;
  logic obs_ready, obs_done, obs_illegal;
  assign obs_ready   = sel8 ? bus8.instr_ready : bus.instr_ready;
  assign obs_done    = sel8 ? done8 : done;
  assign obs_illegal = sel8 ? illegal8 : illegal;

  int tests = 0;
  int fails = 0;

  // Reference model state for the NUM_REGS=16 instance.
  int m_regs [16];
  int m_pc, m_flags, m_alu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int s16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) m_regs[i] = 0;
    m_pc = 0; m_flags = 0; m_alu = 0;
  endtask

  task automatic model_step(input logic [15:0] ins, output bit ill);
    int op, rd, rs, imm, a, bv, res, k, sres;
    bit uses_rs, impl, c, l, f, z, n;
    op = int'(ins[15:12]); rd = int'(ins[11:8]); rs = int'(ins[3:0]); imm = int'(ins[7:0]);
    uses_rs = op inside {0, 2, 4, 5, 6, 7, 9, 11};
    impl    = (op <= 10) || (SHIFT_EN && (op == 11 || op == 12));
    ill     = !impl || rd >= 16 || (uses_rs && rs >= 16);
    m_pc    = (m_pc + 1) % 65536;
    if (ill) return;
    a = m_regs[rd];
    if (uses_rs)       bv = m_regs[rs];
    else if (op == 8)  bv = imm;
    else               bv = (imm >= 128) ? imm + 65280 : imm;
    c = m_flags[4]; l = m_flags[3]; f = m_flags[2];
    case (op)
      0, 1: begin
        res = a + bv; c = res > 65535; l = 1'b0; res = res % 65536;
        sres = s16(a) + s16(bv); f = (sres > 32767) || (sres < -32768);
      end
      2, 3, 9, 10: begin
        c = a < bv; l = a < bv; res = (a - bv + 65536) % 65536;
        sres = s16(a) - s16(bv); f = (sres > 32767) || (sres < -32768);
      end
      4: res = a & bv;
      5: res = a | bv;
      6: res = a ^ bv;
      7, 8: res = bv;
      default: begin
        k = bv & 31;
        if (k >= 16) k = k - 32;
        if (k >= 16 || k <= -16) res = 0;
        else if (k >= 0)         res = (a << k) & 65535;
        else                     res = a >> (-k);
      end
    endcase
    z = (res == 0); n = (res >= 32768);
    m_flags = {c, l, f, z, n};
    m_alu = res;
    if (op != 9 && op != 10) m_regs[rd] = res;
  endtask

  task automatic drive(input logic [15:0] ins, input logic v);
    if (sel8) begin bus8.instr = ins; bus8.instr_valid = v; end
    else      begin bus.instr  = ins; bus.instr_valid  = v; end
  endtask

  // One handshake, then junk on the bus while busy; returns #1 after the retirement edge.
  task automatic issue(input logic [15:0] ins, input logic exp_ill);
    int   waited = 0;
    logic early = 1'b0;
    logic busy = 1'b0;
    @(negedge clk);
    while (obs_ready !== 1'b1 && waited < 16) begin @(negedge clk); waited++; end
    check("ready_before", obs_ready, 1);
    drive(ins, 1'b1);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      early |= obs_done;
      busy  |= obs_ready;
      drive(16'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    drive(16'($urandom), 1'b0);
    check("done_early", early, 0);
    check("ready_busy", busy, 0);
    check("done_pulse", obs_done, 1);
    check("illegal", obs_illegal, exp_ill);
    check("ready_after", obs_ready, 1);
  endtask

  task automatic exec(input logic [15:0] ins);
    bit ill;
    model_step(ins, ill);
    issue(ins, ill);
    check("pc", pc, m_pc);
    check("flags", flags, m_flags);
    if (!ill) check("alu_out", alu_out, m_alu);
    dbg_addr = ins[11:8]; #1;
    check("reg_rd", dbg_data, m_regs[ins[11:8]]);
  endtask

  task automatic read_main(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    dbg_addr = addr; #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic read_8(input logic [3:0] addr, input logic [15:0] exp, input string tag);
    dbg_addr8 = addr; #1;
    check(tag, dbg_data8, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr = '0;  bus.instr_valid = 1'b0;
    bus8.instr = '0; bus8.instr_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", bus.instr_ready, 1);
    check("rst_pc", pc, 16'h0000);
    check("rst_alu", alu_out, 16'h0000);
    check("rst_flags", flags, 5'h00);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_pc8", pc8, 16'hFFFE);
    reset = 1'b1;
    @(negedge clk);

    // MOVI r1,0x7F ; ADDI r1,1
    exec(16'h817F);
    exec(16'h1101);
    read_main(4'd1, 16'h0080, "addi_r1");
    check("addi_flags", flags, 5'b00000);
    check("addi_pc", pc, 16'h0002);

    // MOVI r2,0xFF ; SUB r3,r2 with r3=0
    exec(16'h82FF);
    exec(16'h2302);
    read_main(4'd3, 16'hFF01, "sub_r3");
    check("sub_flags", flags, 5'b11001);

    // MOVI r4,5 ; CMP r4,r4
    exec(16'h8405);
    exec(16'h9404);
    check("cmp_flags", flags, 5'b00010);
    read_main(4'd4, 16'h0005, "cmp_r4");

    // rd==rs reads the operand before the write
    exec(16'h8721);
    exec(16'h0707);
    read_main(4'd7, 16'h0042, "add_self");

    // Shifts
    exec(16'h8501);
    exec(16'hC51F);
`ifdef MULTICYCLE_CORE_SHIFT_EN
    read_main(4'd5, 16'h0000, "lshi_m1");
    exec(16'h8501);
    exec(16'hC50F);
    read_main(4'd5, 16'h8000, "lshi_15");
    exec(16'hB505);
`else
    check("lshi_illegal", illegal, 1);
    read_main(4'd5, 16'h0001, "lshi_nowrite");
    exec(16'hB501);
    check("lsh_illegal", illegal, 1);
`endif

    // Undefined opcodes
    exec(16'hD123);
    exec(16'hE456);
    exec(16'hFFFF);

    // Random instructions against the model
    for (int i = 0; i < 48; i++) exec(16'($urandom));
    for (int i = 0; i < 16; i++) read_main(4'(i), 16'(m_regs[i]), "sweep");
    @(posedge clk); #1;
    check("done_fall", done, 0);

    // Reset during EXEC of MOVI r6,0x55
    @(negedge clk);
    drive(16'h8655, 1'b1);
    @(posedge clk); #1;
    drive(16'h0000, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("mid_ready", bus.instr_ready, 1);
    check("mid_pc", pc, 16'h0000);
    check("mid_flags", flags, 5'h00);
    check("mid_alu", alu_out, 16'h0000);
    check("mid_done", done, 0);
    for (int i = 0; i < 16; i++) read_main(4'(i), 16'h0000, "mid_regs");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", bus.instr_ready, 1);
    check("rel_pc", pc, 16'h0000);
    read_main(4'd6, 16'h0000, "rel_r6");
    model_reset();
    exec(16'h8655);
    read_main(4'd6, 16'h0055, "after_rst_r6");

    // NUM_REGS=8 instance, RESET_PC=0xFFFE
    sel8 = 1'b1;
    check("n8_pc_rst", pc8, 16'hFFFE);
    issue(16'h8133, 1'b0);
    check("n8_pc1", pc8, 16'hFFFF);
    issue(16'hA140, 1'b0);
    check("n8_cmpi_flags", flags8, 5'b11001);
    check("n8_pc_wrap", pc8, 16'h0000);
    issue(16'h0A01, 1'b1);
    check("n8_rd_flags", flags8, 5'b11001);
    check("n8_rd_pc", pc8, 16'h0001);
    read_8(4'd1, 16'h0033, "n8_r1");
    issue(16'h0109, 1'b1);
    check("n8_rs_pc", pc8, 16'h0002);
    check("n8_rs_flags", flags8, 5'b11001);
    issue(16'h8905, 1'b1);
    read_8(4'd9, 16'h0000, "n8_dbg_oob");
    read_8(4'd1, 16'h0033, "n8_r1_keep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
